// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU arbiter slice: ALU op codes and the
// arbiter FSM states.
package alu_pkg;

    localparam int ALU_XLEN = 32;
    localparam int GES_W    = 3;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_SRL = 4'b0010,
        ALU_SRA = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_OR  = 4'b0110,
        ALU_AND = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins and the
// pointer moves just past the winner. No grant leaves the pointer unchanged.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    winner,
    output logic [PW-1:0]    next_ptr
);

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant    = '0;
        winner   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
                next_ptr    = (int'(idx) == N_REQ - 1) ? '0 : idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between N_REQ requesters: grant, one
// cycle of ALU evaluation on registered operands, then a held response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = ALU_XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*XLEN-1:0] req_arg1,
    input  logic [N_REQ*XLEN-1:0] req_arg2,
    input  logic [N_REQ*4-1:0] req_ctrl,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [XLEN-1:0]    rsp_result,
    output logic [GES_W-1:0]   rsp_ges,
    output logic [XLEN-1:0]    alu_arg1,
    output logic [XLEN-1:0]    alu_arg2,
    output logic [3:0]         alu_ctrl,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [GES_W-1:0]   alu_ges
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    next_ptr;
    logic [N_REQ-1:0] grant;
    logic             rsp_done;
    logic             arb_en;
    logic [XLEN-1:0]  sel_arg1;
    logic [XLEN-1:0]  sel_arg2;
    logic [3:0]       sel_ctrl;

    // Arbitration is also gated by reset so no grant is ever shown while held in reset.
    assign rsp_done  = (state == RESP) && rsp_ready[owner];
    assign arb_en    = rst_n && ((state == IDLE) || rsp_done);
    assign req_ready = grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr (
        .en       (arb_en),
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .winner   (winner),
        .next_ptr (next_ptr)
    );

    always_comb begin
        sel_arg1 = '0;
        sel_arg2 = '0;
        sel_ctrl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PW'(i)) begin
                sel_arg1 = req_arg1[i*XLEN +: XLEN];
                sel_arg2 = req_arg2[i*XLEN +: XLEN];
                sel_ctrl = req_ctrl[i*4 +: 4];
            end
        end
    end

    // ALU operand registers only load on a grant, so they hold the last op while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_ges    <= '0;
            alu_arg1   <= '0;
            alu_arg2   <= '0;
            alu_ctrl   <= ALU_ADD;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (rsp_done) begin
                        rsp_valid <= '0;
                    end
                    if (grant != '0) begin
                        alu_arg1 <= sel_arg1;
                        alu_arg2 <= sel_arg2;
                        alu_ctrl <= sel_ctrl;
                        owner    <= winner;
                        ptr      <= next_ptr;
                        state    <= EXEC;
                    end else if (rsp_done) begin
                        state    <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_ges    <= alu_ges;
                    rsp_valid  <= N_REQ'(1) << owner;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
